// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives one outstanding request to instruction memory,
// holds the returned word until decode accepts it, and redirects on taken branches.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] ir;

  // Handshake: a fetch completes in any cycle where imem_req=1 and imem_ack=1;
  // imem_addr is held stable until then. The held instruction is consumed in
  // any HOLD cycle with stall=0. branch_taken beats both and drops any data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC_ALIGNED;
      ir          <= 32'h0000_0000;
      instr_pc    <= RESET_PC_ALIGNED;
      instr_valid <= 1'b0;
    end else if (branch_taken) begin
      pc          <= {branch_target[31:2], 2'b00};
      instr_valid <= 1'b0;
      state       <= FETCH;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            ir          <= imem_rdata;
            instr_pc    <= pc;
            pc          <= pc + 32'd4;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore outputs only: request depends on state, never on ack or branch.
  assign imem_req  = (state == FETCH);
  assign imem_addr = {pc[31:2], 2'b00};
  assign instr     = instr_valid ? ir : 32'h0000_0000;
  assign opcode    = instr[31:26];
  assign pc_plus4  = instr_pc + 32'd4;
  assign fsm_state = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch with a transaction-level fetch model.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic [1:0]  fsm_state;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
    .pc_plus4(pc_plus4), .instr_valid(instr_valid), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: {instruction word, fetch address}
  logic [63:0] exp_q[$];

  // reference model: next fetch address, whether an instruction is held,
  // and whether the one idle cycle after reset is still pending
  logic [31:0] m_pc;
  bit          m_have;
  bit          m_warm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: called at a falling edge. Checks the request side against the
  // model, drives inputs for the coming rising edge, advances the model.
  task automatic step(input bit a, input logic [31:0] rd, input bit s,
                      input bit b, input logic [31:0] t);
    bit exp_req;
    exp_req = !m_warm && !m_have;
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
    chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    imem_ack      = a;
    imem_rdata    = rd;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    if (b) begin
      m_pc   = t & 32'hFFFF_FFFC;
      m_have = 1'b0;
      m_warm = 1'b0;
    end else if (m_warm) begin
      m_warm = 1'b0;
    end else if (!m_have) begin
      if (a) begin
        exp_q.push_back({rd, m_pc});
        m_pc   = m_pc + 32'd4;
        m_have = 1'b1;
      end
    end else if (!s) begin
      m_have = 1'b0;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic reset_pulse();
    imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_opcode", {26'd0, opcode}, 32'd0);
    chk("rst_instr_pc", instr_pc, RESET_PC);
    chk("rst_addr", imem_addr, RESET_PC);
    #1 rst_n = 1'b1;
    exp_q.delete();
    // the rising edge of this cycle carries the DUT through its idle cycle
    m_pc = RESET_PC; m_have = 1'b0; m_warm = 1'b0;
    @(negedge clk);
  endtask

  // monitor: pops on each newly presented instruction, checks it while held
  logic [63:0] cur;
  bit          prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_instr", instr, 32'hXXXX_XXXX);
        end else begin
          cur = exp_q.pop_front();
          chk("instr", instr, cur[63:32]);
          chk("instr_pc", instr_pc, cur[31:0]);
          chk("pc_plus4", pc_plus4, cur[31:0] + 32'd4);
          chk("opcode", {26'd0, opcode}, {26'd0, cur[63:58]});
        end
      end else if (instr_valid) begin
        chk("held_instr", instr, cur[63:32]);
        chk("held_instr_pc", instr_pc, cur[31:0]);
      end else begin
        chk("nop_instr", instr, 32'd0);
      end
      prev_v = instr_valid;
    end
  end

  initial begin
    logic [31:0] rnd;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_req", {31'd0, imem_req}, 32'd0);
    chk("reset_valid", {31'd0, instr_valid}, 32'd0);
    chk("reset_instr", instr, 32'd0);
    chk("reset_instr_pc", instr_pc, RESET_PC);
    chk("reset_pc_plus4", pc_plus4, RESET_PC + 32'd4);
    rst_n = 1'b1;
    m_pc = RESET_PC; m_have = 1'b0; m_warm = 1'b1;

    // sequential fetch, rdata = address
    repeat (8) step(1'b1, m_pc, 1'b0, 1'b0, 32'd0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

    // three wait states at 0x10
    for (int k = 0; k < 4; k++) begin
      chk("wait_addr", imem_addr, 32'h10);
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      step(k == 3, 32'hAABB_0010, 1'b0, 1'b0, 32'd0);
    end
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

    // stall five cycles on a load word
    step(1'b1, 32'h8C22_0004, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("stall_opcode", {26'd0, opcode}, 32'd35);
      chk("stall_instr", instr, 32'h8C22_0004);
      chk("stall_instr_pc", instr_pc, 32'h14);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    end
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("release_req", {31'd0, imem_req}, 32'd1);

    // branch colliding with ack and stall
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0103);
    chk("collide_valid", {31'd0, instr_valid}, 32'd0);
    chk("collide_addr", imem_addr, 32'h100);

    // wrap at the top of the address space, then async reset mid-hold
    step(1'b0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
    chk("wrap_pc_plus4", pc_plus4, 32'd0);
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("wrap_next_addr", imem_addr, 32'd0);
    step(1'b1, 32'h2000_0001, 1'b0, 1'b0, 32'd0);
    reset_pulse();
    chk("post_reset_addr", imem_addr, RESET_PC);
    chk("post_reset_req", {31'd0, imem_req}, 32'd1);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse();
      end else begin
        rnd = $urandom;
        step($urandom_range(0, 9) < 7, rnd, $urandom_range(0, 9) < 4,
             $urandom_range(0, 9) == 0, $urandom);
      end
    end

    repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 Ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Ports: imem_req  out  1  fetch request to instruction memory.
REQ-005 Ports: imem_addr  out  32  word-aligned fetch address.
REQ-006 Ports: imem_rdata  in  32  instruction word, valid only when imem_ack=1.
REQ-007 Ports: imem_ack  in  1  request accepted and imem_rdata valid for the imem_addr presented in the same cycle.
REQ-008 Ports: stall  in  1  downstream decode cannot accept the held instruction.
REQ-009 Ports: branch_taken  in  1  single-cycle redirect pulse (Branch AND Zero from execute).
REQ-010 Ports: branch_target  in  32  redirect address.
REQ-011 Ports: instr  out  32  held instruction; 32'h0000_0000 (NOP) when instr_valid=0.
REQ-012 Ports: opcode  out  6  instr[31:26], feeds the control decoder.
REQ-013 Ports: instr_pc  out  32  address the held instruction was fetched from.
REQ-014 Ports: pc_plus4  out  32  instr_pc + 4, modulo 2^32.
REQ-015 Ports: instr_valid  out  1  instr holds a valid instruction.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, HOLD; encoding free.
REQ-017 IDLE: imem_req=0; unconditional transition to FETCH next cycle.
REQ-018 FETCH: imem_req=1, imem_addr=pc; on imem_ack=1 capture imem_rdata into IR, instr_pc<=pc, pc<=pc+4, instr_valid<=1, go HOLD; no ack: remain FETCH, addr stable.
REQ-019 HOLD: imem_req=0, instr_valid=1; stall=1: remain, IR/instr_pc unchanged; stall=0: instruction consumed this cycle, instr_valid<=0, go FETCH.
REQ-020 At most one fetch outstanding; imem_req SHALL be a Moore output of state only.
REQ-021 PC increment wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000; pc_plus4 wraps identically.
REQ-022 branch_taken=1 in any state: pc<=branch_target with bits [1:0] forced to 2'b00, instr_valid<=0, next state FETCH.
REQ-023 Branch priority: branch_taken overrides stall, overrides imem_ack (rdata discarded, pc not incremented), overrides HOLD consumption.
REQ-024 branch_taken in IDLE: pc<=target, next state FETCH (same as normal exit).
REQ-025 Fetch latency: with immediate ack, first instr_valid=1 two cycles after rst_n deasserts; steady state one instruction per 2 cycles when stall=0.
REQ-026 imem_addr[1:0] SHALL always be 2'b00.

Reset
REQ-027 rst_n=0 asynchronously forces: state IDLE, pc=RESET_PC, IR=0, instr_pc=RESET_PC, instr_valid=0, imem_req=0.
REQ-028 Reset asserted mid-FETCH or mid-HOLD abandons the request/instruction; no output other than reset values visible while rst_n=0.
REQ-029 Reset released: first request at cycle after IDLE, address RESET_PC.

Verification
REQ-030 Reset/sequential: RESET_PC=0, ack always 1, stall=0, rdata=addr -> imem_addr 0,4,8 on successive FETCH cycles; instr 0,4,8 with instr_pc matching, pc_plus4 = 4,8,12.
REQ-031 Wait states: ack held low 3 cycles at addr 0x10 -> imem_req/addr stable 0x10 for 4 cycles, instr_valid rises only after ack.
REQ-032 Stall: stall=1 for 5 cycles in HOLD with instr 0x8C220004 -> instr, opcode=6'd35, instr_pc unchanged, imem_req=0 throughout; release -> FETCH next cycle.
REQ-033 Branch collisions: branch_taken with target 0x0000_0103 in same cycle as ack (rdata 0xDEADBEEF) and stall=1 -> rdata dropped, instr_valid=0, next imem_addr=0x100.
REQ-034 Wrap and async reset: pc at 0xFFFF_FFFC acked -> pc_plus4=0, next addr 0; then rst_n pulsed low mid-HOLD between clock edges -> outputs reset immediately, next request at RESET_PC.
